// File: rtl/workers_cpu_0_cpu_debug_mem_access_if.sv
// Bundles the decoded JTAG command strobes, the CPU Avalon slave port and the
// JTAG-visible monitor registers of the debug memory access block.
interface workers_cpu_0_cpu_debug_mem_access_if #(
  parameter int ADDR_W = 8
);
  logic [37:0]       jdo;
  logic              take_action_ocimem_a;
  logic              take_action_ocimem_b;
  logic              take_no_action_ocimem_a;
  logic [ADDR_W-1:0] avs_address;
  logic              avs_read;
  logic              avs_write;
  logic [31:0]       avs_writedata;
  logic [3:0]        avs_byteenable;
  logic              avs_waitrequest;
  logic [31:0]       avs_readdata;
  logic              avs_readdatavalid;
  logic [31:0]       MonDReg;
  logic [ADDR_W-1:0] MonAReg;
  logic              jtag_busy;

  modport master (
    output jdo, take_action_ocimem_a, take_action_ocimem_b, take_no_action_ocimem_a,
    output avs_address, avs_read, avs_write, avs_writedata, avs_byteenable,
    input  avs_waitrequest, avs_readdata, avs_readdatavalid,
    input  MonDReg, MonAReg, jtag_busy
  );

  modport slave (
    input  jdo, take_action_ocimem_a, take_action_ocimem_b, take_no_action_ocimem_a,
    input  avs_address, avs_read, avs_write, avs_writedata, avs_byteenable,
    output avs_waitrequest, avs_readdata, avs_readdatavalid,
    output MonDReg, MonAReg, jtag_busy
  );
endinterface

// File: rtl/workers_cpu_0_cpu_debug_mem_access.sv
// Debug-monitor RAM owner: decodes JTAG memory strobes, arbitrates the single
// RAM port between JTAG (always first) and the CPU Avalon slave.
module workers_cpu_0_cpu_debug_mem_access #(
  parameter int ADDR_W = 8
) (
  input  logic clk,
  input  logic reset_n,
  workers_cpu_0_cpu_debug_mem_access_if.slave bus
);
  localparam int                DEPTH    = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  logic [31:0]       r_mem [DEPTH];
  logic              r_rd_pend;
  logic              r_wr_pend;
  logic              r_rd_inc;
  logic              r_busy;
  logic [31:0]       r_mon_d;
  logic [ADDR_W-1:0] r_mon_a;
  logic [31:0]       r_readdata;
  logic              r_rdv;

  logic              w_take_a;
  logic              w_take_b;
  logic              w_take_na;
  logic              w_nxt_rd_pend;
  logic              w_nxt_wr_pend;
  logic              w_jtag_pend;
  logic              w_cpu_wr;
  logic              w_cpu_rd;
  logic [ADDR_W-1:0] w_addr;
  logic [31:0]       w_wdata;
  logic [3:0]        w_be;
  logic              w_we;
  logic              w_unused;

  assign w_unused = ^{bus.jdo[37:36], bus.jdo[1:0]};

  // Strobe priority decode and single-port RAM arbitration (JTAG wins).
  always_comb begin
    w_take_b      = bus.take_action_ocimem_b;
    w_take_a      = bus.take_action_ocimem_a & ~bus.take_action_ocimem_b;
    w_take_na     = bus.take_no_action_ocimem_a & ~bus.take_action_ocimem_a
                    & ~bus.take_action_ocimem_b;
    w_nxt_wr_pend = w_take_b;
    w_nxt_rd_pend = (w_take_a & bus.jdo[35]) | w_take_na;
    w_jtag_pend   = r_rd_pend | r_wr_pend;
    w_cpu_wr      = bus.avs_write & ~w_jtag_pend;
    w_cpu_rd      = bus.avs_read & ~bus.avs_write & ~w_jtag_pend;
    if (w_jtag_pend) begin
      w_addr  = r_mon_a;
      w_wdata = r_mon_d;
      w_be    = 4'hF;
      w_we    = r_wr_pend;
    end else begin
      w_addr  = bus.avs_address;
      w_wdata = bus.avs_writedata;
      w_be    = bus.avs_byteenable;
      w_we    = w_cpu_wr;
    end
  end

  // RAM write port; contents survive reset but nothing is written while in it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
    end else if (w_we) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) begin
          r_mem[w_addr][b*8 +: 8] <= w_wdata[b*8 +: 8];
        end
      end
    end
  end

  // Pending flags, monitor registers and registered CPU read return.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_pend  <= 1'b0;
      r_wr_pend  <= 1'b0;
      r_rd_inc   <= 1'b0;
      r_busy     <= 1'b0;
      r_mon_d    <= 32'h0000_0000;
      r_mon_a    <= {ADDR_W{1'b0}};
      r_readdata <= 32'h0000_0000;
      r_rdv      <= 1'b0;
    end else begin
      r_rd_pend <= w_nxt_rd_pend;
      r_wr_pend <= w_nxt_wr_pend;
      r_rd_inc  <= w_take_na;
      // Busy covers the issue cycle and, for reads, the data-return cycle.
      r_busy    <= w_nxt_rd_pend | w_nxt_wr_pend | r_rd_pend;
      if (w_take_a) begin
        r_mon_a <= bus.jdo[ADDR_W+1:2];
      end else if (r_wr_pend | (r_rd_pend & r_rd_inc)) begin
        r_mon_a <= r_mon_a + ADDR_ONE;
      end
      if (w_take_b) begin
        r_mon_d <= bus.jdo[34:3];
      end else if (r_rd_pend) begin
        r_mon_d <= r_mem[w_addr];
      end
      r_rdv <= w_cpu_rd;
      if (w_cpu_rd) begin
        r_readdata <= r_mem[w_addr];
      end
    end
  end

  assign bus.avs_waitrequest   = (bus.avs_read | bus.avs_write) & w_jtag_pend;
  assign bus.avs_readdata      = r_readdata;
  assign bus.avs_readdatavalid = r_rdv;
  assign bus.MonDReg           = r_mon_d;
  assign bus.MonAReg           = r_mon_a;
  assign bus.jtag_busy         = r_busy;
endmodule
